// File: rtl/spectrum_averager_pkg.sv
// Shared types and helpers for the spectrum averager: FSM states, averaging mode,
// and the packed {im, re} complex word format used on both stream interfaces.
package spectrum_averager_pkg;

  localparam int PIPE_LATENCY = 3;
  localparam int CPLX_W       = 16;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ACCUM
  } state_t;

  typedef enum logic {
    MODE_COMPLEX,
    MODE_POWER
  } mode_t;

  typedef struct packed {
    logic signed [CPLX_W-1:0] im;
    logic signed [CPLX_W-1:0] re;
  } cplx_t;

  function automatic logic [2*CPLX_W-1:0] pack_complex(input logic [CPLX_W-1:0] im,
                                                        input logic [CPLX_W-1:0] re);
    return {im, re};
  endfunction

  function automatic cplx_t unpack_complex(input logic [2*CPLX_W-1:0] word);
    cplx_t c;
    c.im = word[2*CPLX_W-1:CPLX_W];
    c.re = word[CPLX_W-1:0];
    return c;
  endfunction

endpackage

// File: rtl/spectrum_acc_ram.sv
// Per-bin accumulator storage: simple dual-port RAM, one write port and one
// registered read port (1-cycle latency, read data held while rd_en is low).
module spectrum_acc_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_spectrum_averager.sv
// Averages 2^N consecutive FFT frames per bin (complex or power), emits one averaged
// frame every 2^T periods through a 3-stage read/add/write pipeline with backpressure.
module axis_spectrum_averager
  import spectrum_averager_pkg::*;
#(
  parameter int FFT_LENGTH_LOG = 8,
  parameter int DATA_WIDTH_IN  = 32,
  parameter int DATA_WIDTH_OUT = 32,
  parameter int ACC_WIDTH      = 48,
  parameter int MAX_LOG_AVG    = 15
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [4:0]                log_count_averages,
  input  logic [4:0]                log_throttle,
  input  logic [DATA_WIDTH_IN-1:0]  s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [DATA_WIDTH_OUT-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      frame_error
);

  localparam int HALF_ACC = ACC_WIDTH / 2;
  localparam int FCNT_W   = (MAX_LOG_AVG > 0) ? MAX_LOG_AVG : 1;
  localparam logic [FFT_LENGTH_LOG-1:0] LAST_BIN = '1;

  state_t state_q, state_d;
  logic   ready_en_q, enable_q;

  logic [FFT_LENGTH_LOG-1:0] bin_cnt;
  logic [FCNT_W-1:0]         frame_cnt;
  logic [31:0]               throttle_cnt;
  mode_t                     cfg_mode;
  logic [4:0]                cfg_n, cfg_t;

  logic              stall, beat, latch_cfg, period_end;
  logic              is_last_bin, frame_err, frame_final, period_emit, keep_running;
  logic [FCNT_W-1:0] mask_n;
  logic [31:0]       mask_t;
  logic [4:0]        n_clamped;

  // pipeline stage 1: beat accepted, RAM read in flight
  logic                      s1_valid, s1_first, s1_emit, s1_last;
  logic [FFT_LENGTH_LOG-1:0] s1_bin;
  cplx_t                     s1_x;
  mode_t                     s1_mode;
  logic [4:0]                s1_n;

  // pipeline stage 2: accumulated sum ready for write-back and scaling
  logic                      s2_valid, s2_emit, s2_last;
  logic [FFT_LENGTH_LOG-1:0] s2_bin;
  logic [ACC_WIDTH-1:0]      s2_sum;
  mode_t                     s2_mode;
  logic [4:0]                s2_n;

  logic [ACC_WIDTH-1:0] rd_data, sum_d;
  logic [31:0]          out_word;

  assign stall        = m_axis_tvalid && !m_axis_tready;
  assign n_clamped    = (log_count_averages > 5'(MAX_LOG_AVG)) ? 5'(MAX_LOG_AVG) : log_count_averages;
  assign mask_n       = ~({FCNT_W{1'b1}} << cfg_n);
  assign mask_t       = ~(32'hFFFF_FFFF << cfg_t);
  assign is_last_bin  = (bin_cnt == LAST_BIN);
  assign frame_err    = (s_axis_tlast != is_last_bin);
  assign frame_final  = (frame_cnt == mask_n);
  assign period_emit  = frame_final && (throttle_cnt == mask_t);
  // once an emitted frame has started on the input side it runs to completion
  assign keep_running = enable || (period_emit && (bin_cnt != '0));
  assign period_end   = beat && !frame_err && is_last_bin && frame_final;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      enable_q   <= enable;
    end
  end

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    beat          = 1'b0;
    latch_cfg     = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_axis_tready = ready_en_q;
        if (enable) begin
          state_d   = SYNC;
          latch_cfg = 1'b1;
        end
      end
      SYNC: begin
        s_axis_tready = 1'b1;
        if (!enable) state_d = IDLE;
        else if (s_axis_tvalid && s_axis_tlast) state_d = ACCUM;
      end
      ACCUM: begin
        s_axis_tready = !stall;
        if (!keep_running) begin
          state_d = IDLE;
        end else begin
          beat = s_axis_tvalid && !stall;
          if (beat && frame_err) state_d = s_axis_tlast ? ACCUM : SYNC;
          else if (beat && is_last_bin && !enable) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      bin_cnt      <= '0;
      frame_cnt    <= '0;
      throttle_cnt <= '0;
      cfg_mode     <= MODE_COMPLEX;
      cfg_n        <= '0;
      cfg_t        <= '0;
      frame_error  <= 1'b0;
    end else begin
      if (enable_q && !enable) frame_error <= 1'b0;
      else if (beat && frame_err) frame_error <= 1'b1;

      if (latch_cfg || period_end) begin
        cfg_mode <= mode_t'(mode);
        cfg_n    <= n_clamped;
        cfg_t    <= log_throttle;
      end

      if (state_q != ACCUM || !keep_running || (beat && frame_err)) begin
        bin_cnt      <= '0;
        frame_cnt    <= '0;
        throttle_cnt <= '0;
      end else if (beat) begin
        bin_cnt <= bin_cnt + FFT_LENGTH_LOG'(1);
        if (is_last_bin) begin
          if (frame_final) begin
            frame_cnt    <= '0;
            throttle_cnt <= (throttle_cnt >= mask_t) ? 32'd0 : throttle_cnt + 32'd1;
          end else begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
          end
        end
      end
    end
  end

  spectrum_acc_ram #(
    .ADDR_W(FFT_LENGTH_LOG),
    .DATA_W(ACC_WIDTH)
  ) u_ram (
    .clk    (aclk),
    .wr_en  (s2_valid && !stall),
    .wr_addr(s2_bin),
    .wr_data(s2_sum),
    .rd_en  (beat),
    .rd_addr(bin_cnt),
    .rd_data(rd_data)
  );

  // First frame of a period overwrites the stale RAM content instead of adding to it.
  logic signed [CPLX_W-1:0]   x_re, x_im;
  logic signed [31:0]         sq_re, sq_im;
  logic [32:0]                power;
  logic [HALF_ACC-1:0]        re_ext, im_ext, acc_re, acc_im;

  always_comb begin
    x_re   = s1_x.re;
    x_im   = s1_x.im;
    re_ext = {{(HALF_ACC-CPLX_W){x_re[CPLX_W-1]}}, x_re};
    im_ext = {{(HALF_ACC-CPLX_W){x_im[CPLX_W-1]}}, x_im};
    sq_re  = 32'(x_re) * 32'(x_re);
    sq_im  = 32'(x_im) * 32'(x_im);
    power  = {1'b0, sq_re} + {1'b0, sq_im};
    acc_re = s1_first ? re_ext : rd_data[HALF_ACC-1:0] + re_ext;
    acc_im = s1_first ? im_ext : rd_data[ACC_WIDTH-1:HALF_ACC] + im_ext;
    if (s1_mode == MODE_POWER) sum_d = s1_first ? ACC_WIDTH'(power) : rd_data + ACC_WIDTH'(power);
    else                       sum_d = {acc_im, acc_re};
  end

  logic signed [HALF_ACC-1:0] out_re_s, out_im_s;

  always_comb begin
    out_re_s = s2_sum[HALF_ACC-1:0];
    out_im_s = s2_sum[ACC_WIDTH-1:HALF_ACC];
    if (s2_mode == MODE_POWER) out_word = 32'(s2_sum >> s2_n);
    else out_word = pack_complex(CPLX_W'(out_im_s >>> s2_n), CPLX_W'(out_re_s >>> s2_n));
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_valid      <= 1'b0;
      s1_emit       <= 1'b0;
      s2_valid      <= 1'b0;
      s2_emit       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (!stall) begin
      s1_valid <= beat && !frame_err;
      s1_first <= (frame_cnt == '0);
      s1_emit  <= period_emit;
      s1_last  <= is_last_bin;
      s1_bin   <= bin_cnt;
      s1_x     <= unpack_complex(s_axis_tdata[2*CPLX_W-1:0]);
      s1_mode  <= cfg_mode;
      s1_n     <= cfg_n;

      s2_valid <= s1_valid;
      s2_emit  <= s1_emit;
      s2_last  <= s1_last;
      s2_bin   <= s1_bin;
      s2_sum   <= sum_d;
      s2_mode  <= s1_mode;
      s2_n     <= s1_n;

      m_axis_tvalid <= s2_valid && s2_emit;
      m_axis_tlast  <= s2_valid && s2_emit && s2_last;
      if (s2_valid && s2_emit) m_axis_tdata <= DATA_WIDTH_OUT'(out_word);
    end
  end

endmodule

// File: tb/tb_axis_spectrum_averager.sv
// Directed bench for axis_spectrum_averager: passthrough, averaging, power, throttle,
// backpressure and framing-error scenarios with hand-computed expectations.
module tb_axis_spectrum_averager;
  import spectrum_averager_pkg::*;

  localparam int NB = 256;

  logic        aclk = 1'b0;
  logic        areset;
  logic        enable;
  logic        mode;
  logic [4:0]  log_count_averages;
  logic [4:0]  log_throttle;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        frame_error;

  axis_spectrum_averager dut (
    .aclk              (aclk),
    .areset            (areset),
    .enable            (enable),
    .mode              (mode),
    .log_count_averages(log_count_averages),
    .log_throttle      (log_throttle),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .frame_error       (frame_error)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int frame_acc0 = 0;
  bit bp_on = 1'b0;
  bit accum_phase = 1'b0;
  int rdy_bad = 0;
  int stall_seen = 0;

  logic [31:0] out_q[$];
  logic        last_q[$];
  int          out_cyc_q[$];
  logic [31:0] fb[NB];
  logic [31:0] xb[NB];

  always @(posedge aclk) cyc++;

  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      out_q.push_back(m_axis_tdata);
      last_q.push_back(m_axis_tlast);
      out_cyc_q.push_back(cyc);
    end
    if (accum_phase) begin
      if (s_axis_tready !== !(m_axis_tvalid && !m_axis_tready)) rdy_bad++;
      if (m_axis_tvalid && !m_axis_tready) stall_seen++;
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      if (bp_on) m_axis_tready = ($urandom_range(0, 1) == 1);
      else       m_axis_tready = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic last);
    int guard;
    guard = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_tready && guard < 500) begin
      @(negedge aclk);
      guard++;
    end
    if (guard >= 500) check_eq("drive_timeout", 32'(guard), 32'd0);
    last_acc_cyc = cyc;
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int last_at);
    for (int b = 0; b <= last_at; b++) begin
      drive_beat(fb[b], b == last_at);
      if (b == 0) frame_acc0 = last_acc_cyc;
    end
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int b = 0; b < NB; b++) fb[b] = v;
  endtask

  task automatic start(input logic md, input logic [4:0] n, input logic [4:0] t);
    mode = md;
    log_count_averages = n;
    log_throttle = t;
    enable = 1'b1;
    tick(1);
    drive_beat(32'h0, 1'b1);
  endtask

  task automatic stop();
    enable = 1'b0;
    tick(8);
  endtask

  task automatic clear_out();
    out_q.delete();
    last_q.delete();
    out_cyc_q.delete();
  endtask

  task automatic wait_out(input int n);
    int guard;
    guard = 0;
    while (out_q.size() < n && guard < 3000) begin
      tick(1);
      guard++;
    end
    tick(6);
  endtask

  task automatic check_const(input string tag, input int base, input int n, input logic [31:0] v);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (base + i >= out_q.size() || out_q[base + i] !== v) bad++;
    check_eq(tag, 32'(bad), 32'd0);
  endtask

  task automatic check_frame(input string tag, input int base);
    int bad;
    bad = 0;
    for (int i = 0; i < NB; i++)
      if (base + i >= out_q.size() || out_q[base + i] !== xb[i]) bad++;
    check_eq(tag, 32'(bad), 32'd0);
  endtask

  function automatic int count_lasts();
    int c;
    c = 0;
    foreach (last_q[i]) if (last_q[i]) c++;
    return c;
  endfunction

  initial begin
    areset = 1'b1;
    enable = 1'b0;
    mode = 1'b0;
    log_count_averages = '0;
    log_throttle = '0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;

    // reset state and tready release timing
    tick(3);
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check_eq("rst_tdata", m_axis_tdata, 32'd0);
    check_eq("rst_ferr", 32'(frame_error), 32'd0);
    check_eq("rst_tready", 32'(s_axis_tready), 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    check_eq("rdy_release", 32'(s_axis_tready), 32'd0);
    @(negedge aclk);
    check_eq("rdy_after", 32'(s_axis_tready), 32'd1);
    tick(1);

    // passthrough, N=0 T=0 complex
    for (int b = 0; b < NB; b++) begin
      fb[b] = {16'(-b), 16'(b)};
      xb[b] = fb[b];
    end
    clear_out();
    start(1'b0, 5'd0, 5'd0);
    send_frame(NB - 1);
    wait_out(NB);
    check_eq("pass_count", 32'(out_q.size()), 32'd256);
    check_eq("pass_latency", 32'(out_cyc_q.size() > 0 ? out_cyc_q[0] - frame_acc0 : -1), 32'(PIPE_LATENCY));
    check_frame("pass_data", 0);
    check_eq("pass_nlast", 32'(count_lasts()), 32'd1);
    check_eq("pass_last255", 32'(last_q.size() == NB ? last_q[NB-1] : 1'b0), 32'd1);
    stop();

    // complex average, N=2: outputs only after frames 3 and 7
    clear_out();
    fill_const({16'hFFCE, 16'h0064});
    start(1'b0, 5'd2, 5'd0);
    for (int f = 0; f < 8; f++) begin
      send_frame(NB - 1);
      tick(6);
      if (f == 2) check_eq("avg_early", 32'(out_q.size()), 32'd0);
      if (f == 3) check_eq("avg_first", 32'(out_q.size()), 32'd256);
      if (f == 6) check_eq("avg_mid", 32'(out_q.size()), 32'd256);
    end
    check_eq("avg_count", 32'(out_q.size()), 32'd512);
    check_const("avg_data", 0, 512, 32'hFFCE_0064);
    stop();

    // power: N=1 with re=3 im=4, N changed mid-period, then N=0 full-scale
    clear_out();
    fill_const({16'd4, 16'd3});
    start(1'b1, 5'd1, 5'd0);
    send_frame(NB - 1);
    log_count_averages = 5'd0;
    send_frame(NB - 1);
    fill_const({16'h8000, 16'h8000});
    send_frame(NB - 1);
    wait_out(512);
    check_eq("pow_count", 32'(out_q.size()), 32'd512);
    check_const("pow_25", 0, NB, 32'd25);
    check_const("pow_max", NB, NB, 32'h8000_0000);
    stop();

    // throttle T=2: frames 3, 7, 11 survive
    clear_out();
    start(1'b0, 5'd0, 5'd2);
    for (int f = 0; f < 12; f++) begin
      fill_const(32'(f));
      send_frame(NB - 1);
    end
    wait_out(768);
    check_eq("thr_count", 32'(out_q.size()), 32'd768);
    check_const("thr_f3", 0, NB, 32'd3);
    check_const("thr_f7", NB, NB, 32'd7);
    check_const("thr_f11", 2 * NB, NB, 32'd11);
    stop();

    // backpressure with random m_axis_tready
    clear_out();
    for (int b = 0; b < NB; b++) begin
      fb[b] = {16'(-b), 16'(b)};
      xb[b] = fb[b];
    end
    start(1'b0, 5'd0, 5'd0);
    rdy_bad = 0;
    stall_seen = 0;
    bp_on = 1'b1;
    accum_phase = 1'b1;
    send_frame(NB - 1);
    send_frame(NB - 1);
    wait_out(512);
    accum_phase = 1'b0;
    bp_on = 1'b0;
    tick(2);
    check_eq("bp_count", 32'(out_q.size()), 32'd512);
    check_frame("bp_data0", 0);
    check_frame("bp_data1", NB);
    check_eq("bp_nlast", 32'(count_lasts()), 32'd2);
    check_eq("bp_ready", 32'(rdy_bad), 32'd0);
    check_eq("bp_stalled", 32'(stall_seen > 0), 32'd1);
    stop();

    // framing error: tlast at bin 100, then a clean N=1 period
    clear_out();
    fill_const(32'h1234_5678);
    start(1'b0, 5'd1, 5'd0);
    send_frame(100);
    check_eq("ferr_set", 32'(frame_error), 32'd1);
    fill_const({16'hFFFC, 16'd10});
    send_frame(NB - 1);
    tick(6);
    check_eq("ferr_noout", 32'(out_q.size()), 32'd0);
    fill_const({16'hFFF8, 16'd20});
    send_frame(NB - 1);
    wait_out(NB);
    check_eq("ferr_count", 32'(out_q.size()), 32'd256);
    check_const("ferr_avg", 0, NB, 32'hFFFA_000F);
    check_eq("ferr_sticky", 32'(frame_error), 32'd1);
    enable = 1'b0;
    tick(2);
    check_eq("ferr_clear", 32'(frame_error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_spectrum_averager.md
Name: axis_spectrum_averager

Overview:
Parametrised successor to the single-mode complex averager in the Fourier transform chain. Sits between the FFT core output and the DMA/stream sink. Accumulates 2^log_count_averages consecutive FFT frames per bin, in either complex (re/im) or power (re²+im²) mode. Emits one averaged frame per 2^log_throttle averaging periods and supports full AXI-Stream backpressure.

Parameters:
FFT_LENGTH_LOG, 8, log2 of bins per frame; must be ≥2.
DATA_WIDTH_IN, 32, packed complex input {im[31:16], re[15:0]}, signed.
DATA_WIDTH_OUT, 32, output word width.
ACC_WIDTH, 48, accumulator width per bin. Complex mode uses ACC_WIDTH/2 per component.
MAX_LOG_AVG, 15, upper clamp for log_count_averages.

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
enable  in  1  run control (GPIO bit 0)
mode  in  1  0 = complex average, 1 = power average
log_count_averages  in  5  frames per average = 2^value, clamped to MAX_LOG_AVG
log_throttle  in  5  emit 1 of every 2^value averaged frames
s_axis_tdata  in  DATA_WIDTH_IN  FFT bin
s_axis_tvalid  in  1
s_axis_tlast  in  1  last bin of frame
s_axis_tready  out  1
m_axis_tdata  out  DATA_WIDTH_OUT  averaged bin
m_axis_tvalid  out  1
m_axis_tlast  out  1
m_axis_tready  in  1
frame_error  out  1  sticky framing error; cleared by areset or enable falling edge

Behaviour:
- Reset: m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, frame_error = 0, s_axis_tready = 0, state = IDLE, all counters = 0. s_axis_tready rises the cycle after areset is released.
- Config (mode, log_count_averages, log_throttle) is latched only on IDLE→SYNC and at each averaging-period boundary. Changes mid-period are ignored until that boundary.
- States:
  - IDLE: tready = 1, input discarded. enable = 1 → SYNC.
  - SYNC: discard input until a beat with tlast, then → ACCUM.
  - ACCUM: bin_cnt addresses the RAM.
    - First frame of a period writes x. Later frames write RAM + x, so no RAM clear is needed.
    - Final frame of a period (frame_cnt = 2^N-1) also drives the output if throttle_cnt = 2^T-1.
    - Otherwise the period is discarded.
    - throttle_cnt increments per completed period and wraps at 2^T.
- Pipeline: 3 stages (RAM read, add, write/output). Input beat k at bin b appears on m_axis 3 cycles after acceptance when unstalled.
- Stall: the whole pipeline holds when m_axis_tvalid && !m_axis_tready. s_axis_tready = !stall outside IDLE/SYNC. No beats are lost or duplicated.
- Arithmetic:
  - Complex mode: re and im are sign-extended into ACC_WIDTH/2 and summed. Output = sum >>> N (arithmetic shift), truncated to 16 bits each, packed {im, re}.
  - Power mode: p = re²+im² (unsigned 33 bits), summed in ACC_WIDTH. Output = (sum >> N) low 32 bits. The maximum value is 2^31, so no saturation is required.
- m_axis_tlast is asserted with the output of bin 2^FFT_LENGTH_LOG-1.
- Framing error: a tlast at bin_cnt ≠ last bin, or a missing tlast at the last bin, causes:
  - frame_error set;
  - current period discarded, with no output beats for it;
  - → SYNC. If the error beat carried tlast, go → ACCUM directly with counters zeroed.
- enable falling:
  - While emitting, finish the current output frame (including tlast), then → IDLE.
  - Otherwise → IDLE at the next cycle, counters zeroed.
  - frame_error cleared.
- areset mid-frame: immediate return to reset state. A partially emitted frame is abandoned without tlast.
- N = 0: every frame is output directly (write-through). T = 0: every period is emitted.

Decomposition:
- Package spectrum_averager_pkg contains:
  - state_t enum {IDLE, SYNC, ACCUM};
  - mode_t enum {MODE_COMPLEX, MODE_POWER};
  - functions pack_complex/unpack_complex;
  - localparam PIPE_LATENCY = 3.
- One sub-module: spectrum_acc_ram, a simple dual-port RAM (depth 2^FFT_LENGTH_LOG, width ACC_WIDTH) with 1-cycle read latency. The read and write addresses are always distinct within a frame, and across the frame wrap because FFT_LENGTH_LOG ≥ 2.

Test Plan:
- Passthrough: FFT_LENGTH_LOG = 8, N = 0, T = 0, complex mode, bin b = {im=-b, re=b} → out bin b = {-b, b}; tlast on bin 255; latency 3 cycles.
- Complex average: N = 2, constant {im=-50, re=100} for 8 frames → exactly 2 output frames, every bin {-50, 100}; zero output beats during frames 0–2 and 4–6.
- Power mode: N = 1, re = 3, im = 4 for 2 frames → one output frame, every bin = 25. re = im = -32768, N = 0 → 2147483648.
- Throttle: N = 0, T = 2, 12 frames with frame index f in every bin → output frames carry 3, 7, 11 only.
- Backpressure: N = 0, m_axis_tready random 50% → output sequence is identical to the tready = 1 run; s_axis_tready = 0 exactly on stalled cycles.
- Framing error: tlast injected at bin 100 → frame_error = 1, no output for that period, correct averages resume from the next full frame. enable toggle clears frame_error.
